// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, default widths, fetch queue entry.
package riscv_pipe_pkg;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned INSTR_W_DEF = 32;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fq_entry_t;

endpackage : riscv_pipe_pkg

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: push side, pop side, flush and occupancy.
interface fetch_queue_if
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               flush;
  logic [CNT_W-1:0]   count;

  // Pipeline side: fetch pushes, decode pops, control flushes
  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  // Queue side
  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );

endinterface : fetch_queue_if

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: circular buffer of {pc, instr} pairs between
// fetch and the IF/ID register, flushed on redirect, NOP bubble when empty.
module fetch_queue
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;
  logic [CNT_W-1:0] cnt_nxt_c;

  // Handshake decode and next occupancy; in_ready ignores out_ready on purpose
  always_comb begin
    full_c    = (cnt == CNT_W'(DEPTH));
    empty_c   = (cnt == '0);
    push_c    = bus.in_valid && !full_c;
    pop_c     = bus.out_ready && !empty_c;
    cnt_nxt_c = cnt;
    if (push_c && !pop_c) begin
      cnt_nxt_c = cnt + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      cnt_nxt_c = cnt - CNT_W'(1);
    end
  end

  // Pointer, occupancy and storage update; flush drops same-cycle traffic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt_nxt_c;
    end
  end

  // Head presentation from registered state only; bubble when empty
  always_comb begin
    bus.in_ready  = !full_c;
    bus.out_valid = !empty_c;
    bus.count     = cnt;
    bus.out_pc    = '0;
    bus.out_instr = INSTR_W'(NOP_INSTR);
    if (!empty_c) begin
      bus.out_pc    = mem[rd_ptr].pc;
      bus.out_instr = mem[rd_ptr].instr;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: driver keeps an occupancy model and
// queues expected head entries; monitor compares on every DUT pop.
module tb_fetch_queue;
  import riscv_pipe_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst;

  fetch_queue_if #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        checks  = 0;
  int        errs    = 0;
  bit        started = 1'b0;
  fq_entry_t exp_q[$];
  int        cur_cnt = 0;
  int        nxt_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model tracks what the queue must hold after the edge
  task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit rdy, input bit fl);
    bit push;
    bit pop;
    @(posedge clk);
    #1;
    cur_cnt       = nxt_cnt;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
    bus.flush     = fl;
    if (fl) begin
      exp_q.delete();
      nxt_cnt = 0;
    end else begin
      pop  = rdy && (cur_cnt != 0);
      push = v && (cur_cnt != int'(DEPTH));
      if (push) exp_q.push_back('{pc: pc, instr: ins});
      nxt_cnt = cur_cnt + int'(push) - int'(pop);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_in_ready"},  64'(bus.in_ready),  64'(1));
    chk({tag, "_count"},     64'(bus.count),     64'(0));
    chk({tag, "_out_pc"},    64'(bus.out_pc),    64'(0));
    chk({tag, "_out_instr"}, 64'(bus.out_instr), 64'(NOP));
  endtask

  // Monitor: status against the model every cycle, head against scoreboard on each pop
  always @(negedge clk) begin
    if (started) begin
      chk("count",     64'(bus.count),     64'(cur_cnt));
      chk("out_valid", 64'(bus.out_valid), 64'(cur_cnt != 0));
      chk("in_ready",  64'(bus.in_ready),  64'(cur_cnt != int'(DEPTH)));
      if (!bus.out_valid) begin
        chk("empty_pc",    64'(bus.out_pc),    64'(0));
        chk("empty_instr", 64'(bus.out_instr), 64'(NOP));
      end else if (bus.out_ready && !bus.flush && !rst) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'(1), 64'(0));
        end else begin
          fq_entry_t e;
          e = exp_q.pop_front();
          chk("head_pc",    64'(bus.out_pc),    64'(e.pc));
          chk("head_instr", 64'(bus.out_instr), 64'(e.instr));
        end
      end
    end
  end

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0030_2023;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    started = 1'b1;

    // Idle after reset
    idle(2, 1'b0);

    // Fill to full, overflow attempt, then drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), prog[i], 1'b0, 1'b0);
    cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    idle(4, 1'b1);
    idle(1, 1'b0);

    // Streaming push+pop with pointer wrap
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Flush with concurrent push and pop, then a fresh push
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h20 + 32'(i * 4), 32'h2000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 32'h0040_0040, 1'b1, 1'b1);
    cycle(1'b1, 32'h100, 32'h0100_0100, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Full queue with simultaneous push and pop: pop only
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h200 + 32'(i * 4), 32'h3000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h210, 32'h3004, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(4, 1'b1);

    // Asynchronous reset while holding two entries
    for (int i = 0; i < 2; i++) cycle(1'b1, 32'h300 + 32'(i * 4), 32'h4000 + 32'(i), 1'b0, 1'b0);
    idle(1, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    cur_cnt = 0;
    nxt_cnt = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    idle(2, 1'b1);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom(), $urandom(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    idle(int'(DEPTH) + 2, 1'b1);
    @(negedge clk);
    #1 chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction fetch stage and the IF/ID register. Buffers up to DEPTH fetched {pc, instruction} pairs so fetch can run ahead while decode stalls. Discards all buffered entries on a branch/redirect flush. Drives a NOP bubble toward decode whenever it is empty.

## Interface

Parameters:
- DEPTH, 4: number of entries; must be a power of two and at least 2.
- PC_W, 32: program counter width.
- INSTR_W, 32: instruction width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  fetch presents a valid pair.
- in_ready  output  1  queue accepts a push this cycle.
- in_pc  input  PC_W  pc of the fetched instruction.
- in_instr  input  INSTR_W  fetched instruction.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode side consumes the head this cycle.
- out_pc  output  PC_W  pc of the head entry.
- out_instr  output  INSTR_W  head instruction, or NOP when empty.
- flush  input  1  synchronous discard of all entries (branch taken / redirect).
- count  output  $clog2(DEPTH+1)  current occupancy.

## Operation

- Storage: circular register array of DEPTH entries, each holding {pc, instr}. Write pointer wr_ptr and read pointer rd_ptr are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. An occupancy counter count distinguishes full from empty.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It does not depend on out_ready, so when the queue is full a same-cycle pop does not enable a push.
- out_valid = (count != 0).
- out_pc: storage[rd_ptr].pc when valid; 0 when empty.
- out_instr: storage[rd_ptr].instr when valid; NOP (32'h00000013, addi x0,x0,0) when empty.
- Push: write the entry at wr_ptr, then wr_ptr+1.
- Pop: rd_ptr+1.
- Count update: push only gives +1; pop only gives −1; push and pop together leave count unchanged (possible only when 0 < count < DEPTH).
- Flush has the highest priority after reset:
  - wr_ptr, rd_ptr and count go to 0.
  - A push or pop in the same cycle is ignored; the in_pc/in_instr of that cycle are dropped.
  - Storage contents are not cleared.
- Push and pop while empty: the push occurs and no pop occurs (out_valid is 0). There is no bypass.
- Outputs are combinational from registered state (pointers, count, array) only. There is no combinational path from any input to any output.

## Timing

- Reset (asynchronous assert; deassert synchronous to clk):
  - count=0, wr_ptr=rd_ptr=0, array cleared to 0.
  - out_valid=0, in_ready=1, out_pc=0, out_instr=32'h00000013.
- Latency: an entry pushed at edge N is visible on out_* after edge N; it can be popped at edge N+1 at the earliest.
- Throughput: one push and one pop per cycle in steady state.
- Flush asserted in cycle N: after edge N, out_valid=0, in_ready=1 and count=0. A push in cycle N+1 is accepted normally.
- Reset during traffic: all entries are lost immediately and outputs return to their reset values without waiting for a clock edge.
- Wrap-around: pointers wrap modulo DEPTH with no bubble. A full queue followed by DEPTH pops must return the entries in push order.

## Structure

- Shared package riscv_pipe_pkg holds:
  - NOP_INSTR = 32'h00000013
  - default PC_W and INSTR_W
  - a packed struct fq_entry_t {pc, instr}
- Single module with no sub-module. The storage array, pointers and counter are inline.

## Test plan

1. Reset, then idle → out_valid=0, in_ready=1, count=0, out_instr=32'h00000013, out_pc=0.
2. Push pc 0x0,0x4,0x8,0xC (instrs 0x00500093, 0x00A00113, 0x002081B3, 0x00302023) with out_ready=0 → count=4, in_ready=0; a fifth push at pc 0x10 is not accepted. Then out_ready=1 for 4 cycles → out_pc sequence 0x0,0x4,0x8,0xC with matching instrs; afterwards count=0.
3. Continuous push+pop for 10 cycles starting at pc 0x0 → count stays at 1 after the first push; out_pc increments by 4 each cycle; pointers wrap twice with no lost or duplicated entry.
4. Queue holding 3 entries; flush asserted together with in_valid=1 (pc 0x40) and out_ready=1 → next cycle count=0, out_valid=0, out_instr=NOP. The 0x40 entry never appears. A push of pc 0x100 the following cycle appears at the head after one edge.
5. Full queue, out_ready=1 and in_valid=1 in the same cycle → exactly one pop and no push; count=3, in_ready=1 next cycle.
6. rst asserted mid-cycle with count=2 → out_valid drops to 0 and count=0 before the next clk edge; all outputs match scenario 1.
